// File: rtl/morse_sequence_checker.sv
// Compares incoming Morse symbols, one at a time, against the ROM pattern for the
// selected letter. Reports a pass or fail pulse and keeps a saturating score.
module morse_sequence_checker #(
  parameter int unsigned     LETTER_W = 5,
  parameter int unsigned     POS_W    = 3,
  parameter int unsigned     TO_W     = 24,
  parameter logic [TO_W-1:0] TIMEOUT  = 24'd12_500_000,
  parameter int unsigned     SCORE_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LETTER_W-1:0]       letter_sel,
  input  logic [1:0]                sym_in,
  input  logic                      sym_valid,
  input  logic                      clear_score,
  output logic [LETTER_W+POS_W-1:0] rom_addr,
  input  logic [1:0]                rom_data,
  output logic                      busy,
  output logic                      match,
  output logic                      mismatch,
  output logic                      done,
  output logic [SCORE_W-1:0]        score
);

  typedef enum logic [2:0] {StIdle, StFetch, StWaitSym, StPass, StFail} state_e;

  localparam logic [1:0]      SymNone     = 2'b00;
  localparam logic [1:0]      SymEnd      = 2'b11;
  localparam logic [TO_W-1:0] TimeoutLast = TIMEOUT - TO_W'(1);

  state_e               state_q, state_d;
  logic [LETTER_W-1:0]  letter_q, letter_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 sym_hit;

  // A 00 symbol is treated as no symbol at all, so it cannot mask a timeout.
  assign sym_hit = sym_valid && (sym_in != SymNone);

  always_comb begin
    state_d  = state_q;
    letter_d = letter_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    score_d  = score_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          letter_d = letter_sel;
          pos_d    = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        cnt_d   = '0;
        state_d = StWaitSym;
      end
      StWaitSym: begin
        cnt_d = cnt_q + TO_W'(1);
        if (sym_hit) begin
          if (sym_in != rom_data) begin
            state_d = StFail;
          end else if (sym_in == SymEnd) begin
            state_d = StPass;
          end else if (pos_q == '1) begin
            // ROM entry ran out of positions without an end marker.
            state_d = StFail;
          end else begin
            pos_d   = pos_q + POS_W'(1);
            state_d = StFetch;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StFail;
        end
      end
      StPass: begin
        state_d = StIdle;
        if (score_q != '1) begin
          score_d = score_q + SCORE_W'(1);
        end
      end
      StFail: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (clear_score) begin
      score_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      letter_q <= '0;
      pos_q    <= '0;
      cnt_q    <= '0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      letter_q <= letter_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
    end
  end

  assign rom_addr = {letter_q, pos_q};
  assign busy     = (state_q != StIdle);
  assign match    = (state_q == StPass);
  assign mismatch = (state_q == StFail);
  assign done     = (state_q == StPass) || (state_q == StFail);
  assign score    = score_q;

endmodule
